// File: rtl/mem_readback_serializer_pkg.sv
// Shared constants and state type for the memory readback serializer.
package mem_readback_serializer_pkg;

    localparam int ADDRW          = 13;
    localparam int ADDRIW         = 11;
    localparam int BITS           = 32;
    localparam int BYTES_PER_WORD = 4;

    localparam logic [2:0] I_MEM        = 3'b100;
    localparam logic [2:0] D_MEM        = 3'b010;
    localparam logic [2:0] IMAGE_BUFFER = 3'b001;

    typedef enum logic [2:0] {
        RB_IDLE,
        RB_READ,
        RB_CAPTURE,
        RB_SEND,
        RB_DONE
    } rb_state_t;

endpackage

// File: rtl/mem_readback_serializer_byte_shifter.sv
// Word load/shift register that hands out one byte at a time, LSB first.
module mem_readback_serializer_byte_shifter
    import mem_readback_serializer_pkg::*;
(
    input  logic            clk,
    input  logic            rst,
    input  logic            load,
    input  logic [BITS-1:0] load_data,
    input  logic            shift,
    output logic [7:0]      byte_out,
    output logic            last_byte
);

    logic [BITS-1:0] shift_reg;
    logic [1:0]      byte_idx;

    always_ff @(posedge clk) begin
        if (rst) begin
            shift_reg <= '0;
            byte_idx  <= '0;
        end else if (load) begin
            shift_reg <= load_data;
            byte_idx  <= '0;
        end else if (shift) begin
            shift_reg <= shift_reg >> 8;
            byte_idx  <= byte_idx + 2'd1;
        end
    end

    assign byte_out  = shift_reg[7:0];
    assign last_byte = (byte_idx == 2'(BYTES_PER_WORD - 1));

endmodule

// File: rtl/mem_readback_serializer.sv
// Reads words from instruction or data memory and streams them LSB-first to the UART TX.
module mem_readback_serializer
    import mem_readback_serializer_pkg::*;
(
    input  logic             clk,
    input  logic             rst,
    input  logic             start,
    input  logic [2:0]       dest,
    input  logic [ADDRW-1:0] base_addr,
    input  logic [ADDRW:0]   word_cnt,
    output logic             busy,
    output logic             done,
    output logic             err,
    output logic             imem_rd_en,
    output logic             dmem_rd_en,
    output logic [ADDRW-1:0] mem_addr,
    input  logic [BITS-1:0]  imem_rdata,
    input  logic [BITS-1:0]  dmem_rdata,
    output logic [7:0]       tx_data,
    output logic             tx_valid,
    input  logic             tx_ready
);

    // I_MEM addresses live in the low ADDRIW bits and wrap there.
    localparam logic [ADDRW-1:0] IMEM_MASK = ADDRW'((1 << ADDRIW) - 1);

    rb_state_t        state;
    logic             is_imem;
    logic [ADDRW:0]   remain;
    logic [ADDRW-1:0] next_addr;
    logic             shift;
    logic             load;
    logic             last_byte;

    assign next_addr = is_imem ? ((mem_addr + 1'b1) & IMEM_MASK) : (mem_addr + 1'b1);
    assign load      = (state == RB_CAPTURE);
    assign shift     = (state == RB_SEND) && tx_ready;

    mem_readback_serializer_byte_shifter u_byte_shifter (
        .clk       (clk),
        .rst       (rst),
        .load      (load),
        .load_data (is_imem ? imem_rdata : dmem_rdata),
        .shift     (shift),
        .byte_out  (tx_data),
        .last_byte (last_byte)
    );

    always_ff @(posedge clk) begin
        if (rst) begin
            state      <= RB_IDLE;
            busy       <= 1'b0;
            done       <= 1'b0;
            err        <= 1'b0;
            imem_rd_en <= 1'b0;
            dmem_rd_en <= 1'b0;
            tx_valid   <= 1'b0;
            mem_addr   <= '0;
            remain     <= '0;
            is_imem    <= 1'b0;
        end else begin
            done       <= 1'b0;
            err        <= 1'b0;
            imem_rd_en <= 1'b0;
            dmem_rd_en <= 1'b0;
            case (state)
                RB_IDLE: begin
                    if (start) begin
                        if (dest != I_MEM && dest != D_MEM) begin
                            err <= 1'b1;
                        end else if (word_cnt == '0) begin
                            done <= 1'b1;
                        end else begin
                            is_imem    <= (dest == I_MEM);
                            mem_addr   <= (dest == I_MEM) ? (base_addr & IMEM_MASK) : base_addr;
                            remain     <= word_cnt;
                            busy       <= 1'b1;
                            imem_rd_en <= (dest == I_MEM);
                            dmem_rd_en <= (dest == D_MEM);
                            state      <= RB_READ;
                        end
                    end
                end
                RB_READ: state <= RB_CAPTURE;
                RB_CAPTURE: begin
                    tx_valid <= 1'b1;
                    state    <= RB_SEND;
                end
                RB_SEND: begin
                    if (tx_ready && last_byte) begin
                        tx_valid <= 1'b0;
                        remain   <= remain - 1'b1;
                        mem_addr <= next_addr;
                        if (remain == (ADDRW+1)'(1)) begin
                            done  <= 1'b1;
                            busy  <= 1'b0;
                            state <= RB_DONE;
                        end else begin
                            imem_rd_en <= is_imem;
                            dmem_rd_en <= !is_imem;
                            state      <= RB_READ;
                        end
                    end
                end
                RB_DONE: state <= RB_IDLE;
                default: state <= RB_IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_mem_readback_serializer.sv
// Scoreboard bench: stimulus queues expected bytes/reads, a negedge monitor pops and compares.
module tb_mem_readback_serializer;
    import mem_readback_serializer_pkg::*;

    logic             clk = 1'b0;
    logic             rst;
    logic             start;
    logic [2:0]       dest;
    logic [ADDRW-1:0] base_addr;
    logic [ADDRW:0]   word_cnt;
    logic             busy, done, err;
    logic             imem_rd_en, dmem_rd_en;
    logic [ADDRW-1:0] mem_addr;
    logic [BITS-1:0]  imem_rdata, dmem_rdata;
    logic [7:0]       tx_data;
    logic             tx_valid;
    logic             tx_ready;

    always #5 clk = ~clk;

    mem_readback_serializer dut (
        .clk        (clk),
        .rst        (rst),
        .start      (start),
        .dest       (dest),
        .base_addr  (base_addr),
        .word_cnt   (word_cnt),
        .busy       (busy),
        .done       (done),
        .err        (err),
        .imem_rd_en (imem_rd_en),
        .dmem_rd_en (dmem_rd_en),
        .mem_addr   (mem_addr),
        .imem_rdata (imem_rdata),
        .dmem_rdata (dmem_rdata),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready)
    );

    logic [BITS-1:0] dmem [0:(1<<ADDRW)-1];
    logic [BITS-1:0] imem [0:(1<<ADDRIW)-1];

    always @(posedge clk) begin
        if (dmem_rd_en) dmem_rdata <= dmem[mem_addr];
        if (imem_rd_en) imem_rdata <= imem[mem_addr[ADDRIW-1:0]];
    end

    typedef struct packed {
        logic             is_imem;
        logic [ADDRW-1:0] addr;
    } rd_exp_t;

    logic [7:0] byte_q [$];
    rd_exp_t    rd_q   [$];
    int checks = 0, errors = 0;
    int done_cnt = 0, err_cnt = 0;
    int held = 0;
    logic rmode = 1'b0;

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s actual=%0h expected=%0h", name, act, exp);
        end
    endtask

    // Monitor
    logic       prev_stall = 1'b0;
    logic [7:0] prev_data  = 8'h00;
    always @(negedge clk) begin
        if (rst) begin
            prev_stall = 1'b0;
        end else begin
            if (prev_stall) begin
                check("stall_valid", {31'b0, tx_valid}, 32'd1);
                check("stall_data", {24'b0, tx_data}, {24'b0, prev_data});
            end
            if (tx_valid && tx_ready) begin
                if (byte_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_byte actual=%0h expected=none", tx_data);
                end else begin
                    logic [7:0] eb;
                    eb = byte_q.pop_front();
                    check("tx_byte", {24'b0, tx_data}, {24'b0, eb});
                end
            end
            if (imem_rd_en && dmem_rd_en) begin
                checks++; errors++;
                $display("FAIL both_rd_en actual=11 expected=one-hot");
            end else if (imem_rd_en || dmem_rd_en) begin
                if (rd_q.size() == 0) begin
                    checks++; errors++;
                    $display("FAIL unexpected_read actual=addr %0h expected=none", mem_addr);
                end else begin
                    rd_exp_t er;
                    er = rd_q.pop_front();
                    check("rd_addr", {19'b0, mem_addr}, {19'b0, er.addr});
                    check("rd_is_imem", {31'b0, imem_rd_en}, {31'b0, er.is_imem});
                end
            end
            if (done) done_cnt++;
            if (err) err_cnt++;
            prev_stall = tx_valid && !tx_ready;
            prev_data  = tx_data;
        end
    end

    // tx_ready driver for the stall test: random, plus 5 forced-low cycles on byte 0x22
    always @(posedge clk) begin
        #1;
        if (rmode) begin
            if (tx_valid && tx_data == 8'h22 && held < 5) begin
                tx_ready = 1'b0;
                held++;
            end else begin
                tx_ready = 1'($urandom_range(0, 1));
            end
        end
    end

    task automatic issue(input logic [2:0] d, input logic [ADDRW-1:0] b, input logic [ADDRW:0] c);
        @(posedge clk); #1;
        dest = d; base_addr = b; word_cnt = c; start = 1'b1;
        @(posedge clk); #1;
        start = 1'b0;
    endtask

    // Returns the index of the negedge (1 = first after the accepting edge) where done appears.
    task automatic wait_done(input int budget, output int n);
        n = 0;
        while (n < budget) begin
            @(negedge clk);
            n++;
            if (done) break;
        end
        if (!done) begin
            checks++; errors++;
            $display("FAIL done_timeout actual=no_done expected=done within %0d", budget);
        end
    endtask

    task automatic push_dmem_cmd();
        byte_q.push_back(8'h44); byte_q.push_back(8'h33);
        byte_q.push_back(8'h22); byte_q.push_back(8'h11);
        byte_q.push_back(8'hDD); byte_q.push_back(8'hCC);
        byte_q.push_back(8'hBB); byte_q.push_back(8'hAA);
        rd_q.push_back('{1'b0, 13'h010});
        rd_q.push_back('{1'b0, 13'h011});
    endtask

    initial begin
        int n, d0, e0;
        #2_000_000;
        $display("FAIL watchdog actual=running expected=finished");
        $fatal(1, "watchdog");
    end

    initial begin
        int n, d0, e0;
        rst = 1'b1; start = 1'b0; dest = '0; base_addr = '0; word_cnt = '0; tx_ready = 1'b1;
        for (int i = 0; i < (1<<ADDRW); i++) dmem[i] = 32'h5A000000 | i;
        for (int i = 0; i < (1<<ADDRIW); i++) imem[i] = 32'hA5000000 | i;
        dmem[13'h010] = 32'h11223344;
        dmem[13'h011] = 32'hAABBCCDD;
        imem[11'h7FF] = 32'hDEADBEEF;
        imem[11'h000] = 32'h01020304;

        repeat (3) @(negedge clk);
        check("rst_busy", {31'b0, busy}, 0);
        check("rst_done", {31'b0, done}, 0);
        check("rst_err", {31'b0, err}, 0);
        check("rst_imem_rd_en", {31'b0, imem_rd_en}, 0);
        check("rst_dmem_rd_en", {31'b0, dmem_rd_en}, 0);
        check("rst_tx_valid", {31'b0, tx_valid}, 0);
        check("rst_tx_data", {24'b0, tx_data}, 0);
        check("rst_mem_addr", {19'b0, mem_addr}, 0);
        @(posedge clk); #1 rst = 1'b0;

        // D_MEM dump, tx_ready high: 2 words x 6 cycles after the accepting edge
        push_dmem_cmd();
        d0 = done_cnt;
        issue(D_MEM, 13'h010, 14'd2);
        check("t1_busy_after_start", {31'b0, busy}, 1);
        wait_done(200, n);
        check("t1_cycles", n - 1, 12);
        check("t1_busy_at_done", {31'b0, busy}, 0);
        repeat (3) @(negedge clk);
        check("t1_bytes_left", byte_q.size(), 0);
        check("t1_reads_left", rd_q.size(), 0);
        check("t1_done_pulses", done_cnt - d0, 1);

        // Same command with random backpressure and a 5-cycle stall on 0x22
        push_dmem_cmd();
        held = 0; rmode = 1'b1;
        d0 = done_cnt;
        issue(D_MEM, 13'h010, 14'd2);
        wait_done(400, n);
        @(posedge clk); #1 rmode = 1'b0; tx_ready = 1'b1;
        repeat (2) @(negedge clk);
        check("t2_stall_applied", held, 5);
        check("t2_bytes_left", byte_q.size(), 0);
        check("t2_reads_left", rd_q.size(), 0);
        check("t2_done_pulses", done_cnt - d0, 1);

        // Rejected destinations
        e0 = err_cnt;
        issue(IMAGE_BUFFER, 13'h010, 14'd2);
        @(negedge clk);
        check("t3_err_001", {31'b0, err}, 1);
        check("t3_busy_001", {31'b0, busy}, 0);
        @(negedge clk);
        check("t3_err_clear", {31'b0, err}, 0);
        issue(3'b110, 13'h010, 14'd2);
        @(negedge clk);
        check("t3_err_110", {31'b0, err}, 1);
        check("t3_busy_110", {31'b0, busy}, 0);
        repeat (6) @(negedge clk);
        check("t3_err_pulses", err_cnt - e0, 2);
        check("t3_busy_idle", {31'b0, busy}, 0);

        // I_MEM wrap from 0x7FF to 0x000
        byte_q.push_back(8'hEF); byte_q.push_back(8'hBE);
        byte_q.push_back(8'hAD); byte_q.push_back(8'hDE);
        byte_q.push_back(8'h04); byte_q.push_back(8'h03);
        byte_q.push_back(8'h02); byte_q.push_back(8'h01);
        rd_q.push_back('{1'b1, 13'h7FF});
        rd_q.push_back('{1'b1, 13'h000});
        issue(I_MEM, 13'h07FF, 14'd2);
        wait_done(200, n);
        check("t4_cycles", n - 1, 12);
        repeat (2) @(negedge clk);
        check("t4_bytes_left", byte_q.size(), 0);
        check("t4_reads_left", rd_q.size(), 0);

        // Zero-length command
        d0 = done_cnt;
        issue(D_MEM, 13'h020, 14'd0);
        @(negedge clk);
        check("t5_done", {31'b0, done}, 1);
        check("t5_busy", {31'b0, busy}, 0);
        repeat (6) @(negedge clk);
        check("t5_done_pulses", done_cnt - d0, 1);

        // Reset while byte 1 of word 0 is on the bus
        byte_q.push_back(8'h44);
        rd_q.push_back('{1'b0, 13'h010});
        d0 = done_cnt;
        issue(D_MEM, 13'h010, 14'd2);
        repeat (3) begin @(posedge clk); #1; end
        check("t6_byte1_present", {24'b0, tx_data}, 32'h33);
        rst = 1'b1;
        @(posedge clk); #1 rst = 1'b0;
        @(negedge clk);
        check("t6_busy", {31'b0, busy}, 0);
        check("t6_tx_valid", {31'b0, tx_valid}, 0);
        check("t6_tx_data", {24'b0, tx_data}, 0);
        check("t6_mem_addr", {19'b0, mem_addr}, 0);
        check("t6_rd_en", {30'b0, imem_rd_en, dmem_rd_en}, 0);
        repeat (10) @(negedge clk);
        check("t6_no_done", done_cnt - d0, 0);
        check("t6_bytes_left", byte_q.size(), 0);

        // Fresh command after reset
        push_dmem_cmd();
        d0 = done_cnt;
        issue(D_MEM, 13'h010, 14'd2);
        wait_done(200, n);
        check("t7_cycles", n - 1, 12);
        repeat (3) @(negedge clk);
        check("t7_bytes_left", byte_q.size(), 0);
        check("t7_done_pulses", done_cnt - d0, 1);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
